// File: rtl/kf8254_bus_control_if.sv
// CPU-side bus of the 8254-class timer.
// The CPU drives the strobes, address and write data. The timer returns the captured data byte.
interface kf8254_bus_control_if;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic [1:0] address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;

  modport master (
    output chip_select_n,
    output read_enable_n,
    output write_enable_n,
    output address,
    output data_bus_in,
    input  internal_data_bus
  );

  modport slave (
    input  chip_select_n,
    input  read_enable_n,
    input  write_enable_n,
    input  address,
    input  data_bus_in,
    output internal_data_bus
  );
endinterface

// File: rtl/kf8254_bus_control.sv
// Bus-side control decoder for the 8254-class timer.
// Synchronises the CPU strobes, captures address/data and emits one-clock command strobes.
module kf8254_bus_control #(
  parameter int unsigned NUM_COUNTERS = 3,
  parameter int unsigned SYNC_STAGES  = 0,
  parameter bit          READBACK_EN  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  kf8254_bus_control_if.slave     bus,
  output logic [NUM_COUNTERS-1:0] write_counter,
  output logic [NUM_COUNTERS-1:0] write_control,
  output logic [NUM_COUNTERS-1:0] latch_counter,
  output logic [NUM_COUNTERS-1:0] readback_count,
  output logic [NUM_COUNTERS-1:0] readback_status,
  output logic [NUM_COUNTERS-1:0] read_counter,
  output logic [NUM_COUNTERS-1:0] read_done
);

  logic cs_s, rd_s, wr_s;

  // Strobes are delayed SYNC_STAGES clocks; flops idle high so reset looks like an idle bus.
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign cs_s = bus.chip_select_n;
    assign rd_s = bus.read_enable_n;
    assign wr_s = bus.write_enable_n;
  end else begin : g_sync
    logic [2:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 3'b111;
      end else begin
        sync_q[0] <= {bus.chip_select_n, bus.read_enable_n, bus.write_enable_n};
        for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign cs_s = sync_q[SYNC_STAGES-1][2];
    assign rd_s = sync_q[SYNC_STAGES-1][1];
    assign wr_s = sync_q[SYNC_STAGES-1][0];
  end

  logic wr_act, rd_act;
  logic wr_act_q, rd_act_q;
  logic wr_event, rd_event;
  logic [1:0] addr_q;
  logic [7:0] data_q;

  assign wr_act = ~cs_s & ~wr_s;
  assign rd_act = ~cs_s & ~rd_s & ~wr_act;

  // A cycle ends when the strobe rises while chip select was still low the clock before.
  assign wr_event = wr_act_q & wr_s;
  assign rd_event = rd_act_q & rd_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
      addr_q   <= 2'b00;
      data_q   <= 8'h00;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (wr_act) begin
        data_q <= bus.data_bus_in;
        addr_q <= bus.address;
      end else if (rd_act) begin
        addr_q <= bus.address;
      end
    end
  end

  assign bus.internal_data_bus = data_q;

  logic [NUM_COUNTERS-1:0] wc_d, ctl_d, lat_d, rbc_d, rbs_d, rdd_d;
  logic [NUM_COUNTERS-1:0] wc_q, ctl_q, lat_q, rbc_q, rbs_q, rdd_q;
  logic [1:0] sc, rw;

  assign sc = data_q[7:6];
  assign rw = data_q[5:4];

  always_comb begin
    wc_d  = '0;
    ctl_d = '0;
    lat_d = '0;
    rbc_d = '0;
    rbs_d = '0;
    rdd_d = '0;
    if (wr_event) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        if (addr_q == 2'(i)) wc_d[i] = 1'b1;
      end
      if (addr_q == 2'b11) begin
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
          if (sc == 2'(i)) begin
            if (rw == 2'b00) lat_d[i] = 1'b1;
            else             ctl_d[i] = 1'b1;
          end
        end
        // Read-back: D[3:1] select counters, ~D5 latches count, ~D4 latches status.
        if (READBACK_EN && sc == 2'b11 && !data_q[0]) begin
          for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            if (data_q[i+1]) begin
              rbc_d[i] = ~data_q[5];
              rbs_d[i] = ~data_q[4];
            end
          end
        end
      end
    end
    if (rd_event) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        if (addr_q == 2'(i)) rdd_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wc_q  <= '0;
      ctl_q <= '0;
      lat_q <= '0;
      rbc_q <= '0;
      rbs_q <= '0;
      rdd_q <= '0;
    end else begin
      wc_q  <= wc_d;
      ctl_q <= ctl_d;
      lat_q <= lat_d;
      rbc_q <= rbc_d;
      rbs_q <= rbs_d;
      rdd_q <= rdd_d;
    end
  end

  assign write_counter   = wc_q;
  assign write_control   = ctl_q;
  assign latch_counter   = lat_q;
  assign readback_count  = rbc_q;
  assign readback_status = rbs_q;
  assign read_done       = rdd_q;

  always_comb begin
    read_counter = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      read_counter[i] = rd_act & (bus.address == 2'(i));
    end
  end

endmodule

// File: tb/tb_kf8254_bus_control.sv
// Scoreboard bench for kf8254_bus_control: three configurations driven with identical bus cycles.
// dut_a: N=3 S=0 RB=1, dut_b: N=2 S=0 RB=1, dut_c: N=3 S=2 RB=0.
module tb_kf8254_bus_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  kf8254_bus_control_if bus_a ();
  kf8254_bus_control_if bus_b ();
  kf8254_bus_control_if bus_c ();

  logic [2:0] wc_a, ctl_a, lat_a, rbc_a, rbs_a, rc_a, rd_a;
  logic [1:0] wc_b, ctl_b, lat_b, rbc_b, rbs_b, rc_b, rd_b;
  logic [2:0] wc_c, ctl_c, lat_c, rbc_c, rbs_c, rc_c, rd_c;

  kf8254_bus_control #(.NUM_COUNTERS(3), .SYNC_STAGES(0), .READBACK_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave),
    .write_counter(wc_a), .write_control(ctl_a), .latch_counter(lat_a),
    .readback_count(rbc_a), .readback_status(rbs_a), .read_counter(rc_a), .read_done(rd_a)
  );

  kf8254_bus_control #(.NUM_COUNTERS(2), .SYNC_STAGES(0), .READBACK_EN(1'b1)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave),
    .write_counter(wc_b), .write_control(ctl_b), .latch_counter(lat_b),
    .readback_count(rbc_b), .readback_status(rbs_b), .read_counter(rc_b), .read_done(rd_b)
  );

  kf8254_bus_control #(.NUM_COUNTERS(3), .SYNC_STAGES(2), .READBACK_EN(1'b0)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c.slave),
    .write_counter(wc_c), .write_control(ctl_c), .latch_counter(lat_c),
    .readback_count(rbc_c), .readback_status(rbs_c), .read_counter(rc_c), .read_done(rd_c)
  );

  typedef struct {
    int          cyc;
    logic [17:0] pulses;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  function automatic logic [17:0] pk(input logic [2:0] wc, input logic [2:0] ctl,
                                     input logic [2:0] lat, input logic [2:0] rbc,
                                     input logic [2:0] rbs, input logic [2:0] rd);
    return {wc, ctl, lat, rbc, rbs, rd};
  endfunction

  task automatic drive(input logic cs, input logic rd, input logic wr,
                       input logic [1:0] addr, input logic [7:0] data);
    bus_a.chip_select_n = cs; bus_a.read_enable_n = rd; bus_a.write_enable_n = wr;
    bus_a.address = addr;     bus_a.data_bus_in = data;
    bus_b.chip_select_n = cs; bus_b.read_enable_n = rd; bus_b.write_enable_n = wr;
    bus_b.address = addr;     bus_b.data_bus_in = data;
    bus_c.chip_select_n = cs; bus_c.read_enable_n = rd; bus_c.write_enable_n = wr;
    bus_c.address = addr;     bus_c.data_bus_in = data;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Release happens just after edge `rel`; pulse is visible after edge rel+1+SYNC_STAGES.
  task automatic push_all(input int rel, input logic [17:0] ea, input logic [17:0] eb,
                          input logic [17:0] ec);
    exp_t e;
    if (ea != 0) begin e.cyc = rel + 1; e.pulses = ea; q_a.push_back(e); end
    if (eb != 0) begin e.cyc = rel + 1; e.pulses = eb; q_b.push_back(e); end
    if (ec != 0) begin e.cyc = rel + 3; e.pulses = ec; q_c.push_back(e); end
  endtask

  task automatic wr_cycle(input logic [1:0] addr, input logic [7:0] data, input int nlow,
                          input int gap, input logic [17:0] ea, input logic [17:0] eb,
                          input logic [17:0] ec);
    drive(1'b0, 1'b1, 1'b0, addr, data);
    tick(nlow);
    drive(1'b1, 1'b1, 1'b1, addr, data);
    push_all(cyc, ea, eb, ec);
    tick(gap);
  endtask

  task automatic rd_cycle(input logic [1:0] addr, input int nlow, input bit cs_early,
                          input logic [17:0] ea, input logic [17:0] eb, input logic [17:0] ec);
    drive(1'b0, 1'b0, 1'b1, addr, 8'h00);
    tick(nlow);
    if (cs_early) begin
      drive(1'b1, 1'b0, 1'b1, addr, 8'h00);
      tick(1);
    end
    drive(1'b1, 1'b1, 1'b1, addr, 8'h00);
    push_all(cyc, ea, eb, ec);
    tick(4);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idb(input logic [7:0] exp);
    check("idb_a", 32'(bus_a.internal_data_bus), 32'(exp));
    check("idb_b", 32'(bus_b.internal_data_bus), 32'(exp));
    check("idb_c", 32'(bus_c.internal_data_bus), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'({wc_a, ctl_a, lat_a, rbc_a, rbs_a, rc_a, rd_a}), 32'd0);
    check({tag, "_b"}, 32'({wc_b, ctl_b, lat_b, rbc_b, rbs_b, rc_b, rd_b}), 32'd0);
    check({tag, "_c"}, 32'({wc_c, ctl_c, lat_c, rbc_c, rbs_c, rc_c, rd_c}), 32'd0);
    check_idb(8'h00);
  endtask

  task automatic mon(input int id, input logic [17:0] act);
    exp_t e;
    bit   have;
    if (act == 0) return;
    have = 1'b0;
    case (id)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL pulse dut%0d: got %h at cycle %0d, expected no pulse", id, act, cyc);
    end else if (e.cyc != cyc || e.pulses !== act) begin
      errors++;
      $display("FAIL pulse dut%0d: got %h at cycle %0d, expected %h at cycle %0d",
               id, act, cyc, e.pulses, e.cyc);
    end
  endtask

  // Monitor: pops expectations on any pulse; also models the combinational read_counter level.
  always @(negedge clock) begin
    logic       rd_act_m;
    logic [2:0] exp_rc;
    if (!reset) begin
      mon(0, {wc_a, ctl_a, lat_a, rbc_a, rbs_a, rd_a});
      mon(1, {1'b0, wc_b, 1'b0, ctl_b, 1'b0, lat_b, 1'b0, rbc_b, 1'b0, rbs_b, 1'b0, rd_b});
      mon(2, {wc_c, ctl_c, lat_c, rbc_c, rbs_c, rd_c});
      rd_act_m = !bus_a.chip_select_n && !bus_a.read_enable_n && bus_a.write_enable_n;
      exp_rc = 3'b000;
      if (rd_act_m && bus_a.address != 2'b11) exp_rc = 3'b001 << bus_a.address;
      check("read_counter_a", 32'(rc_a), 32'(exp_rc));
      check("read_counter_b", 32'(rc_b), 32'(exp_rc[1:0]));
    end
  end

  initial begin
    drive(1'b1, 1'b1, 1'b1, 2'b00, 8'h00);
    #3;
    check_all_zero("reset_state");
    tick(1);
    reset = 1'b0;
    tick(2);

    // Control word mode write, counter latch, empty read-back
    wr_cycle(2'd3, 8'h34, 3, 4, pk(0, 3'b001, 0, 0, 0, 0), pk(0, 3'b001, 0, 0, 0, 0),
             pk(0, 3'b001, 0, 0, 0, 0));
    check_idb(8'h34);
    wr_cycle(2'd3, 8'h80, 3, 4, pk(0, 0, 3'b100, 0, 0, 0), 18'd0, pk(0, 0, 3'b100, 0, 0, 0));
    wr_cycle(2'd3, 8'hC0, 3, 4, 18'd0, 18'd0, 18'd0);

    // Read-back
    wr_cycle(2'd3, 8'hCA, 2, 4, pk(0, 0, 0, 3'b101, 3'b101, 0), pk(0, 0, 0, 3'b001, 3'b001, 0),
             18'd0);
    check_idb(8'hCA);
    wr_cycle(2'd3, 8'hCB, 2, 4, 18'd0, 18'd0, 18'd0);
    wr_cycle(2'd3, 8'hDC, 2, 4, pk(0, 0, 0, 3'b110, 0, 0), pk(0, 0, 0, 3'b010, 0, 0), 18'd0);
    wr_cycle(2'd3, 8'h64, 2, 4, pk(0, 3'b010, 0, 0, 0, 0), pk(0, 3'b010, 0, 0, 0, 0),
             pk(0, 3'b010, 0, 0, 0, 0));

    // Counter data writes, including an address beyond dut_b's counters
    wr_cycle(2'd0, 8'h12, 3, 4, pk(3'b001, 0, 0, 0, 0, 0), pk(3'b001, 0, 0, 0, 0, 0),
             pk(3'b001, 0, 0, 0, 0, 0));
    check_idb(8'h12);
    wr_cycle(2'd2, 8'h99, 1, 4, pk(3'b100, 0, 0, 0, 0, 0), 18'd0, pk(3'b100, 0, 0, 0, 0, 0));

    // Reads
    rd_cycle(2'd1, 4, 1'b0, pk(0, 0, 0, 0, 0, 3'b010), pk(0, 0, 0, 0, 0, 3'b010),
             pk(0, 0, 0, 0, 0, 3'b010));
    rd_cycle(2'd1, 4, 1'b1, 18'd0, 18'd0, 18'd0);
    rd_cycle(2'd2, 2, 1'b0, pk(0, 0, 0, 0, 0, 3'b100), 18'd0, pk(0, 0, 0, 0, 0, 3'b100));
    rd_cycle(2'd3, 2, 1'b0, 18'd0, 18'd0, 18'd0);
    check_idb(8'h99);

    // Write and read strobes together: write wins
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h21);
    tick(3);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h21);
    push_all(cyc, pk(3'b001, 0, 0, 0, 0, 0), pk(3'b001, 0, 0, 0, 0, 0),
             pk(3'b001, 0, 0, 0, 0, 0));
    tick(4);
    check_idb(8'h21);

    // Back-to-back writes with a one-clock gap
    wr_cycle(2'd1, 8'h05, 2, 1, pk(3'b010, 0, 0, 0, 0, 0), pk(3'b010, 0, 0, 0, 0, 0),
             pk(3'b010, 0, 0, 0, 0, 0));
    wr_cycle(2'd1, 8'h06, 2, 6, pk(3'b010, 0, 0, 0, 0, 0), pk(3'b010, 0, 0, 0, 0, 0),
             pk(3'b010, 0, 0, 0, 0, 0));
    check_idb(8'h06);

    // Reset in the middle of a write strobe
    drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h55);
    tick(2);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick(1);
    reset = 1'b0;
    tick(4);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h55);
    push_all(cyc, pk(3'b001, 0, 0, 0, 0, 0), pk(3'b001, 0, 0, 0, 0, 0),
             pk(3'b001, 0, 0, 0, 0, 0));
    tick(6);
    check_idb(8'h55);

    tick(10);
    check("pending_a", 32'(q_a.size()), 32'd0);
    check("pending_b", 32'(q_b.size()), 32'd0);
    check("pending_c", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
